// File: rtl/cpu_types_pkg.sv
// Shared datapath/memory types: RAM handshake states, word type, arbiter FSM and grant encodings.
// Latency: none (types only).
// Backpressure: none (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM model handshake state as seen by the memory-side master.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter sequencing: decide, hold the RAM request, then report.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    // Which datapath port owns the current (or most recent) access.
    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Latched RAM operation kind.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of instruction/data ports onto one RAM port, with error and timeout handling.
// Latency: grant in IDLE, strobes next cycle, hit one cycle after ACCESS/ERROR/timeout (min 2 cycles).
// Backpressure: requesters hold REN/WEN until hit; one access in flight, new grants only from IDLE.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT  = 255,
    parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      ihit,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dhit,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    arb_state_t      state, nextState;
    grant_t          lastGrant, port;
    op_t             op;
    word_t           latAddr, latStore;
    word_t           iloadReg, dloadReg;
    logic [CW-1:0]   waitCnt;
    logic            errReg;

    logic            iPend, dPend;
    logic            grantI, grantD;
    logic            accDone, accFail;

    assign iPend = iREN;
    assign dPend = dREN | dWEN;

    // Next-state and output decode; outputs depend on registered state only.
    always_comb begin
        nextState = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        accDone   = 1'b0;
        accFail   = 1'b0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iload     = iloadReg;
        dload     = dloadReg;
        err       = errReg;
        case (state)
            IDLE: begin
                // Data wins when alone or when instruction had the last turn.
                if (dPend && (!iPend || lastGrant == INSTR)) begin
                    grantD    = 1'b1;
                    nextState = DACC;
                end else if (iPend) begin
                    grantI    = 1'b1;
                    nextState = IACC;
                end
            end
            IACC, DACC: begin
                ramREN   = (op == READ);
                ramWEN   = (op == WRITE);
                ramaddr  = latAddr;
                ramstore = latStore;
                // Completion takes precedence over a coincident timeout.
                if (ramstate == ACCESS) begin
                    accDone   = 1'b1;
                    nextState = RESP;
                end else if (ramstate == ERROR || waitCnt == TMAX) begin
                    accFail   = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                ihit      = (port == INSTR);
                dhit      = (port == DATA);
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // FSM state, grant latches, saturating wait counter and load/error capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            lastGrant <= DATA;
            port      <= DATA;
            op        <= READ;
            latAddr   <= '0;
            latStore  <= '0;
            waitCnt   <= '0;
            iloadReg  <= '0;
            dloadReg  <= '0;
            errReg    <= 1'b0;
        end else begin
            state <= nextState;
            if (grantD) begin
                lastGrant <= DATA;
                port      <= DATA;
                op        <= dWEN ? WRITE : READ;
                latAddr   <= daddr;
                latStore  <= dstore;
                waitCnt   <= '0;
            end else if (grantI) begin
                lastGrant <= INSTR;
                port      <= INSTR;
                op        <= READ;
                latAddr   <= iaddr;
                latStore  <= '0;
                waitCnt   <= '0;
            end else if ((state == IACC || state == DACC) && waitCnt != TMAX) begin
                waitCnt <= waitCnt + CW'(1);
            end
            if (accDone || accFail) begin
                if (port == INSTR) begin
                    iloadReg <= accDone ? ramload : ERR_WORD;
                end else begin
                    dloadReg <= accDone ? ramload : ERR_WORD;
                end
            end
            if (accFail) begin
                errReg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout so the timeout path is reachable.
// Latency: stimulus driven 1 time unit after each rising edge, outputs checked right after.
// Backpressure: RAM side modelled by directly driving ramstate/ramload per cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      ihit;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dhit;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    int nAssert = 0;
    int nFail   = 0;

    mem_arbiter #(.TIMEOUT(4), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // Reset state
        tick();
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        RST = 1'b0;
        tick();

        // Contention: both held, 1-cycle completion; grants alternate I,D,I,D
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
        ramstate = ACCESS;
        chk("cont_idle_noREN", 32'(ramREN), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            ramload = 32'h1111_0000 + 32'(k);
            chk("cont_ramaddr", ramaddr, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("cont_ramREN", 32'(ramREN), 32'd1);
            tick();
            if (k == 3) begin
                iREN = 1'b0; dREN = 1'b0;
            end
            chk("cont_ihit", 32'(ihit), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_dhit", 32'(dhit), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k % 2 == 0) chk("cont_iload", iload, 32'h1111_0000 + 32'(k));
            else            chk("cont_dload", dload, 32'h1111_0000 + 32'(k));
            tick();
        end
        ramstate = FREE;
        chk("cont_idle_after", 32'(ramREN), 32'd0);
        tick();
        chk("cont_no_regrant", 32'(ramREN), 32'd0);

        // Single read, ACCESS on 2nd access cycle, request withdrawn after grant
        dREN = 1'b1; daddr = 32'h40;
        tick();
        dREN = 1'b0; ramstate = BUSY;
        chk("rd_ramREN", 32'(ramREN), 32'd1);
        chk("rd_ramaddr", ramaddr, 32'h40);
        chk("rd_dhit_early", 32'(dhit), 32'd0);
        tick();
        ramstate = ACCESS; ramload = 32'h1234;
        chk("rd_dhit_early2", 32'(dhit), 32'd0);
        tick();
        ramstate = FREE;
        chk("rd_dhit", 32'(dhit), 32'd1);
        chk("rd_dload", dload, 32'h1234);
        chk("rd_ihit", 32'(ihit), 32'd0);
        chk("rd_resp_ramREN", 32'(ramREN), 32'd0);
        tick();
        chk("rd_dhit_once", 32'(dhit), 32'd0);

        // Write priority and latching
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hCAFEF00D;
        tick();
        dREN = 1'b0; dWEN = 1'b0; daddr = 32'h999; dstore = 32'h0; ramstate = BUSY;
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h80);
        chk("wr_ramstore", ramstore, 32'hCAFEF00D);
        tick();
        ramstate = ACCESS; ramload = 32'h7777;
        chk("wr_ramaddr_hold", ramaddr, 32'h80);
        chk("wr_ramstore_hold", ramstore, 32'hCAFEF00D);
        tick();
        ramstate = FREE;
        chk("wr_dhit", 32'(dhit), 32'd1);
        chk("wr_resp_ramWEN", 32'(ramWEN), 32'd0);
        chk("wr_resp_ramaddr", ramaddr, 32'd0);
        chk("wr_err", 32'(err), 32'd0);
        tick();

        // RAM error on instruction port, then sticky err through a good access
        iREN = 1'b1; iaddr = 32'h300;
        tick();
        iREN = 1'b0; ramstate = ERROR;
        chk("er_err_before", 32'(err), 32'd0);
        tick();
        ramstate = FREE;
        chk("er_ihit", 32'(ihit), 32'd1);
        chk("er_iload", iload, 32'hBAD1BAD1);
        chk("er_err", 32'(err), 32'd1);
        tick();
        iREN = 1'b1; iaddr = 32'h304;
        tick();
        iREN = 1'b0; ramstate = ACCESS; ramload = 32'h5555;
        tick();
        ramstate = FREE;
        chk("er_ok_ihit", 32'(ihit), 32'd1);
        chk("er_ok_iload", iload, 32'h5555);
        chk("er_sticky", 32'(err), 32'd1);
        tick();

        // Timeout: BUSY held, hit 6 cycles after grant with error word
        dREN = 1'b1; daddr = 32'h44;
        tick();
        dREN = 1'b0; ramstate = BUSY;
        for (int i = 1; i <= 5; i++) begin
            chk("to_dhit_wait", 32'(dhit), 32'd0);
            chk("to_ramREN_wait", 32'(ramREN), 32'd1);
            tick();
        end
        ramstate = FREE;
        chk("to_dhit", 32'(dhit), 32'd1);
        chk("to_dload", dload, 32'hBAD1BAD1);
        chk("to_err", 32'(err), 32'd1);
        tick();

        // Reset mid-access, then first contested grant goes to instruction port
        dREN = 1'b1; daddr = 32'h10;
        tick();
        dREN = 1'b0; ramstate = BUSY;
        chk("mr_ramREN_pre", 32'(ramREN), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("mr_ramREN", 32'(ramREN), 32'd0);
        chk("mr_dhit", 32'(dhit), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_ramaddr", ramaddr, 32'd0);
        tick();
        RST = 1'b0; ramstate = FREE;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
        tick();
        iREN = 1'b0; dREN = 1'b0;
        chk("mr_first_grant", ramaddr, 32'h100);
        chk("mr_grant_REN", 32'(ramREN), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the pipelined datapath's instruction-fetch and data-access ports and a single shared RAM port. It grants one request at a time, latches its address and store data, and holds the RAM request until the RAM reports completion. It returns one hit pulse with registered load data, handles RAM error and timeout, and sits between the datapath/cache side and the RAM model.

## Interface
- TIMEOUT, 255, maximum cycles a granted access waits for RAM completion before it is forced to error.
- ERR_WORD, 32'hBAD1BAD1, load value returned on an errored access.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iload  out  32  instruction read data; valid while ihit=1.
- ihit  out  1  one-cycle completion pulse for the instruction port.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data; valid while dhit=1.
- dhit  out  1  one-cycle completion pulse for the data port.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramstate=ACCESS.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky error flag; cleared only by RST.

## Operation
- FSM states: IDLE, IACC, DACC, RESP.
- **IDLE**
  - Only data pending, or data and instruction both pending with last_grant=INSTR: go to DACC and set last_grant=DATA.
  - Only instruction pending, or both pending with last_grant=DATA: go to IACC and set last_grant=INSTR.
  - Nothing pending: stay in IDLE.
  - On grant, latch addr, store data, op (READ/WRITE) and port. Clear the wait counter.
- **IACC / DACC**
  - Drive the RAM outputs from the latched fields only: ramREN=1 for a read, ramWEN=1 for a write, never both.
  - Input changes after the grant have no effect.
  - The wait counter increments every cycle.
- **Exit from IACC/DACC**
  - ramstate=ACCESS: capture ramload into the port's load register and go to RESP.
  - ramstate=ERROR, or wait counter = TIMEOUT: capture ERR_WORD, set err, and go to RESP.
  - If ACCESS and the timeout coincide, ACCESS wins.
- **RESP**
  - Pulse the granted port's hit for exactly one cycle. Load data is valid during this cycle.
  - The RAM outputs are 0. Requests are ignored. Next state is IDLE.
- Writes also pulse the hit. Load data on a write is don't-care and holds the captured ramload.
- A request withdrawn after its grant still completes and still pulses its hit.
- Request arriving during RESP: sampled in the IDLE cycle that follows.
- The `last_grant` (`grant_t`) register resets to DATA, so the first contested grant goes to the instruction port.

## Timing
- Grant decision happens in IDLE at cycle t. RAM strobes are asserted from cycle t+1.
- ramstate=ACCESS first seen at cycle t+k (k≥1) puts the hit at cycle t+k+1.
- Minimum latency from the request cycle to the hit is 2 cycles. Minimum back-to-back issue interval is 3 cycles.
- Errored access: the hit comes at most TIMEOUT+2 cycles after the grant.
- All outputs are registered or decoded from registered state only; no combinational input-to-output paths.
- **Reset (async, mid-operation included):**
  - state=IDLE, last_grant=DATA, counter=0.
  - ihit=dhit=ramREN=ramWEN=err=0.
  - iload=dload=ramaddr=ramstore=0.
  - These values take effect immediately, without waiting for a clock edge.
- The wait counter is clog2(TIMEOUT+1) bits and saturates; it cannot wrap.

## Structure
- Shared package `cpu_types_pkg` holds:
  - `ramstate_t` (FREE, BUSY, ACCESS, ERROR), `word_t`;
  - new `arb_state_t` (IDLE, IACC, DACC, RESP) and `grant_t` (INSTR, DATA).
- Single module, no sub-modules.
- The FSM, the latch registers and the wait counter sit in one always_ff with async RST. The output decode is in one always_comb.

## Test plan
- **Single read:** dREN, daddr=0x40, RAM returns ACCESS on the 2nd access cycle with ramload=0x1234 -> dhit exactly one cycle at grant+3, dload=0x1234, ihit=0.
- **Contention:** iREN and dREN held continuously, each access completes in 1 cycle -> grants alternate I,D,I,D starting with the instruction port; no port gets two consecutive grants.
- **Write priority and latching:** dREN=dWEN=1, daddr=0x80, dstore=0xCAFEF00D, daddr changed after the grant -> ramWEN=1, ramREN=0, ramaddr stays 0x80 and ramstore stays 0xCAFEF00D until ACCESS.
- **RAM error:** ramstate=ERROR during IACC -> ihit pulses with iload=0xBAD1BAD1; err=1 and remains 1 through later successful accesses.
- **Timeout:** TIMEOUT=4, ramstate held BUSY -> hit pulses 6 cycles after the grant with the error word; err=1.
- **Reset mid-access:** assert RST while in DACC with ramREN=1 -> ramREN, dhit and err drop to 0 before the next clock edge; after release, the first contested grant goes to the instruction port.
